pixel_write_queue: RTL and testbench

- Buffers pixel-write commands from game logic (snake/food/score renderers) and drains them into the shared framebuffer SRAM.
- Writes happen only while the display scan is not reading SRAM, i.e. during the write window.
- Sits directly upstream of the SRAM pins and the framebuffer drawer.
- Owns the SRAM address mux, the DQ output enable and WE_N during write windows; the scan owns them otherwise.

---
 rtl/pixel_write_queue_pkg.sv | 28 ++
 rtl/pixel_write_queue_if.sv | 19 +
 rtl/pixel_write_queue_sync_fifo.sv | 58 +++++
 rtl/pixel_write_queue.sv | 186 ++++++++++++++++++
 tb/tb_pixel_write_queue.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_write_queue_pkg.sv
// pixel_write_queue_pkg: shared framebuffer widths, command/state types and
// the address-packing helper for the pixel write queue.
package pixel_write_queue_pkg;

  localparam int FB_X_W     = 9;
  localparam int FB_Y_W     = 9;
  localparam int FB_COLOR_W = 15;

  typedef struct packed {
    logic [FB_X_W-1:0]     x;
    logic [FB_Y_W-1:0]     y;
    logic [FB_COLOR_W-1:0] color;
  } pix_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

  // SRAM address packs x into the MSBs, y into the LSBs.
  function automatic logic [FB_X_W+FB_Y_W-1:0] fb_addr(input logic [FB_X_W-1:0] x,
                                                       input logic [FB_Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// pixel_write_queue_if: valid/ready pixel command channel from the renderers.
interface pixel_write_queue_if
  import pixel_write_queue_pkg::*;
#(
  parameter int X_W     = FB_X_W,
  parameter int Y_W     = FB_Y_W,
  parameter int COLOR_W = FB_COLOR_W
);

  logic               in_valid;
  logic               in_ready;
  logic [X_W-1:0]     in_x;
  logic [Y_W-1:0]     in_y;
  logic [COLOR_W-1:0] in_color;

  modport master (output in_valid, in_x, in_y, in_color, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_color, output in_ready);

endinterface

// File: rtl/pixel_write_queue_sync_fifo.sv
// pixel_write_queue_sync_fifo: single-clock FIFO with an occupancy counter.
// Full and empty come from the registered level, so a pop while full does not
// free a push slot until the following cycle.
module pixel_write_queue_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: buffers renderer pixel writes and drains them into the
// framebuffer SRAM only while the scan leaves SRAM free (wr_window). Each write
// is a 4-cycle IDLE/SETUP/STROBE/HOLD sequence; outside a write the scan
// address passes straight through to the SRAM pins.
// Optional feature: define PIXEL_QUEUE_CLEAR_EN to add clear_req/clear_busy,
// which sweeps the whole framebuffer with a latched fill colour.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int X_W     = FB_X_W,
  parameter int Y_W     = FB_Y_W,
  parameter int COLOR_W = FB_COLOR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_write_queue_if.slave     cmd,
  input  logic                   wr_window,
  input  logic [X_W+Y_W-1:0]     scan_addr,
  output logic [X_W+Y_W-1:0]     sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef PIXEL_QUEUE_CLEAR_EN
  ,
  input  logic                   clear_req,
  output logic                   clear_busy
`endif
);

  localparam int AW = X_W + Y_W;
  localparam int EW = AW + COLOR_W;

  wr_state_t        state;
  wr_state_t        state_next;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;

  logic             start_fifo;
  logic             start_write;
  logic [AW-1:0]    wr_addr;
  logic [COLOR_W-1:0] wr_data;

  assign fifo_wdata   = {cmd.in_x, cmd.in_y, cmd.in_color};
  assign cmd.in_ready = ~fifo_full;

`ifdef PIXEL_QUEUE_CLEAR_EN
  logic               start_clear;
  logic [AW-1:0]      clear_addr;
  logic [COLOR_W-1:0] fill_color;
  logic               cur_is_clear;
  logic               cur_last;

  assign start_clear = (state == IDLE) && wr_window && clear_busy;
  assign start_fifo  = (state == IDLE) && wr_window && !fifo_empty && !clear_busy;
  assign start_write = start_fifo || start_clear;
`else
  assign start_fifo  = (state == IDLE) && wr_window && !fifo_empty;
  assign start_write = start_fifo;
`endif

  assign fifo_pop = start_fifo;

  pixel_write_queue_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.in_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Sticky overflow flag: any attempted push while full is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (cmd.in_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a write only starts from IDLE; once started it always completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_write) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output register holding the address/data of the write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start_fifo) begin
      wr_addr <= fifo_rdata[EW-1:COLOR_W];
      wr_data <= fifo_rdata[COLOR_W-1:0];
    end
`ifdef PIXEL_QUEUE_CLEAR_EN
    else if (start_clear) begin
      wr_addr <= clear_addr;
      wr_data <= fill_color;
    end
`endif
  end

  // SRAM pin mux: scan owns the bus in IDLE, the queue owns it for SETUP/STROBE/HOLD.
  always_comb begin
    sram_addr   = scan_addr;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      SETUP, HOLD: begin
        sram_addr   = wr_addr;
        sram_dq_out = 16'(wr_data);
        sram_dq_oe  = 1'b1;
      end
      STROBE: begin
        sram_addr   = wr_addr;
        sram_dq_out = 16'(wr_data);
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      default: begin
        sram_addr = scan_addr;
      end
    endcase
  end

`ifdef PIXEL_QUEUE_CLEAR_EN
  // Clear sweep control: latch the fill colour, walk every address, drop busy after the last HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_busy   <= 1'b0;
      fill_color   <= '0;
      clear_addr   <= '0;
      cur_is_clear <= 1'b0;
      cur_last     <= 1'b0;
    end else begin
      if (clear_req && !clear_busy) begin
        clear_busy <= 1'b1;
        fill_color <= cmd.in_color;
        clear_addr <= '0;
      end
      if (start_clear) begin
        clear_addr   <= clear_addr + AW'(1);
        cur_is_clear <= 1'b1;
        cur_last     <= &clear_addr;
      end else if (start_fifo) begin
        cur_is_clear <= 1'b0;
      end
      if ((state == HOLD) && cur_is_clear && cur_last) begin
        clear_busy   <= 1'b0;
        cur_is_clear <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: directed tests for pixel_write_queue (default build),
// with a queue-based reference model compared against the SRAM pins every cycle.
module tb_pixel_write_queue;
  import pixel_write_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = FB_X_W + FB_Y_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_window;
  logic [AW-1:0]          scan_addr;
  logic [AW-1:0]          sram_addr;
  logic [15:0]            sram_dq_out;
  logic                   sram_dq_oe;
  logic                   sram_we_n;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
`ifdef PIXEL_QUEUE_CLEAR_EN
  logic                   clear_req = 1'b0;
  logic                   clear_busy;
`endif

  pixel_write_queue_if #(.X_W(FB_X_W), .Y_W(FB_Y_W), .COLOR_W(FB_COLOR_W)) cmd_if ();

  pixel_write_queue #(
    .DEPTH   (DEPTH),
    .X_W     (FB_X_W),
    .Y_W     (FB_Y_W),
    .COLOR_W (FB_COLOR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .wr_window   (wr_window),
    .scan_addr   (scan_addr),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .level       (level),
    .overflow    (overflow)
`ifdef PIXEL_QUEUE_CLEAR_EN
    ,
    .clear_req   (clear_req),
    .clear_busy  (clear_busy)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int cyc = 0;

  // Reference model: a queue of accepted commands plus the position inside the 4-cycle write.
  pix_cmd_t mq[$];
  pix_cmd_t m_cur = '0;
  int       m_phase = 0;
  logic     m_ovf = 1'b0;

  // Strobes observed on the SRAM pins.
  logic [AW-1:0] st_addr[$];
  logic [15:0]   st_data[$];
  int            st_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelStep();
    int       sz;
    bit       pop_now;
    pix_cmd_t e;
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_phase = 0;
      m_cur   = '0;
    end else begin
      sz      = mq.size();
      pop_now = (m_phase == 0) && (wr_window == 1'b1) && (sz > 0);
      if (cmd_if.in_valid && sz == DEPTH) m_ovf = 1'b1;
      if (m_phase == 0) m_phase = pop_now ? 1 : 0;
      else              m_phase = (m_phase + 1) % 4;
      if (pop_now) m_cur = mq.pop_front();
      if (cmd_if.in_valid && sz < DEPTH) begin
        e.x     = cmd_if.in_x;
        e.y     = cmd_if.in_y;
        e.color = cmd_if.in_color;
        mq.push_back(e);
      end
    end
  endtask

  task automatic compareAll();
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_dq;
    exp_addr = (m_phase == 0) ? scan_addr : fb_addr(m_cur.x, m_cur.y);
    exp_dq   = (m_phase == 0) ? 16'h0000 : {1'b0, m_cur.color};
    checkOutput("level",     32'(level),       32'(mq.size()));
    checkOutput("in_ready",  32'(cmd_if.in_ready), 32'(mq.size() < DEPTH));
    checkOutput("overflow",  32'(overflow),    32'(m_ovf));
    checkOutput("we_n",      32'(sram_we_n),   32'(m_phase != 2));
    checkOutput("dq_oe",     32'(sram_dq_oe),  32'(m_phase != 0));
    checkOutput("sram_addr", 32'(sram_addr),   32'(exp_addr));
    checkOutput("dq_out",    32'(sram_dq_out), 32'(exp_dq));
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) compareAll();
  end

  initial forever begin
    @(negedge clk);
    if (sram_we_n === 1'b0) begin
      st_addr.push_back(sram_addr);
      st_data.push_back(sram_dq_out);
      st_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clearLog();
    st_addr.delete();
    st_data.delete();
    st_cyc.delete();
  endtask

  // Present one command for exactly one rising edge.
  task automatic applyStimulus(input logic v, input logic [8:0] x, input logic [8:0] y, input logic [14:0] c);
    cmd_if.in_valid = v;
    cmd_if.in_x     = x;
    cmd_if.in_y     = y;
    cmd_if.in_color = c;
    step();
  endtask

  initial begin
    rst             = 1'b1;
    wr_window       = 1'b0;
    scan_addr       = 18'h12345;
    cmd_if.in_valid = 1'b0;
    cmd_if.in_x     = '0;
    cmd_if.in_y     = '0;
    cmd_if.in_color = '0;

    // Reset then idle.
    step();
    check_en = 1'b1;
    step();
    rst = 1'b0;
    waitNeg(1);
    checkOutput("rst_addr",     32'(sram_addr), 32'h12345);
    checkOutput("rst_we_n",     32'(sram_we_n), 32'd1);
    checkOutput("rst_oe",       32'(sram_dq_oe), 32'd0);
    checkOutput("rst_level",    32'(level), 32'd0);
    checkOutput("rst_ready",    32'(cmd_if.in_ready), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);

    // Single write with the window open.
    step();
    wr_window = 1'b1;
    clearLog();
    applyStimulus(1'b1, 9'd5, 9'd7, 15'h7C00);
    cmd_if.in_valid = 1'b0;
    waitNeg(1);
    checkOutput("t1_c1_oe", 32'(sram_dq_oe), 32'd0);
    waitNeg(1);
    checkOutput("t1_c2_oe",   32'(sram_dq_oe), 32'd1);
    checkOutput("t1_c2_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("t1_c2_addr", 32'(sram_addr), 32'h00A07);
    waitNeg(1);
    checkOutput("t1_c3_we_n", 32'(sram_we_n), 32'd0);
    checkOutput("t1_c3_addr", 32'(sram_addr), 32'h00A07);
    checkOutput("t1_c3_dq",   32'(sram_dq_out), 32'h7C00);
    waitNeg(1);
    checkOutput("t1_c4_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("t1_c4_oe",   32'(sram_dq_oe), 32'd1);
    waitNeg(1);
    checkOutput("t1_c5_oe",   32'(sram_dq_oe), 32'd0);
    checkOutput("t1_strobes", 32'(st_addr.size()), 32'd1);

    // Window gating: three queued entries, then drained in order 4 cycles apart.
    step();
    wr_window = 1'b0;
    scan_addr = 18'h3FFFF;
    clearLog();
    applyStimulus(1'b1, 9'd1, 9'd2, 15'h0001);
    applyStimulus(1'b1, 9'd3, 9'd4, 15'h0002);
    applyStimulus(1'b1, 9'd10, 9'd20, 15'h7FFF);
    cmd_if.in_valid = 1'b0;
    waitNeg(5);
    checkOutput("t2_level",   32'(level), 32'd3);
    checkOutput("t2_nowrite", 32'(st_addr.size()), 32'd0);
    step();
    wr_window = 1'b1;
    waitNeg(16);
    checkOutput("t2_strobes", 32'(st_addr.size()), 32'd3);
    if (st_addr.size() == 3) begin
      checkOutput("t2_addr0", 32'(st_addr[0]), 32'h00202);
      checkOutput("t2_addr1", 32'(st_addr[1]), 32'h00604);
      checkOutput("t2_addr2", 32'(st_addr[2]), 32'h01414);
      checkOutput("t2_data2", 32'(st_data[2]), 32'h7FFF);
      checkOutput("t2_gap01", 32'(st_cyc[1] - st_cyc[0]), 32'd4);
      checkOutput("t2_gap12", 32'(st_cyc[2] - st_cyc[1]), 32'd4);
    end

    // Full / overflow: 16 accepted, 17th dropped.
    step();
    wr_window = 1'b0;
    clearLog();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 9'(i), 9'(i + 1), 15'(i + 100));
    end
    cmd_if.in_valid = 1'b0;
    waitNeg(1);
    checkOutput("t3_ready_full", 32'(cmd_if.in_ready), 32'd0);
    checkOutput("t3_level_full", 32'(level), 32'd16);
    checkOutput("t3_ovf_before", 32'(overflow), 32'd0);
    step();
    applyStimulus(1'b1, 9'd16, 9'd17, 15'd116);
    cmd_if.in_valid = 1'b0;
    waitNeg(1);
    checkOutput("t3_ovf_after",  32'(overflow), 32'd1);
    checkOutput("t3_level_17",   32'(level), 32'd16);
    step();
    wr_window = 1'b1;
    waitNeg(72);
    checkOutput("t3_strobes",    32'(st_addr.size()), 32'd16);
    if (st_addr.size() == 16) begin
      checkOutput("t3_first_addr", 32'(st_addr[0]), 32'h00001);
      checkOutput("t3_first_data", 32'(st_data[0]), 32'h0064);
      checkOutput("t3_last_addr",  32'(st_addr[15]), 32'h01E10);
      checkOutput("t3_last_data",  32'(st_data[15]), 32'h0073);
    end
    checkOutput("t3_drained",    32'(level), 32'd0);
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Window drop in SETUP: the write still completes, nothing else pops.
    step();
    wr_window = 1'b0;
    clearLog();
    applyStimulus(1'b1, 9'd7, 9'd1, 15'h0ABC);
    applyStimulus(1'b1, 9'd8, 9'd2, 15'h0DEF);
    cmd_if.in_valid = 1'b0;
    wr_window = 1'b1;
    step();
    wr_window = 1'b0;
    waitNeg(1);
    checkOutput("t4_setup_oe",  32'(sram_dq_oe), 32'd1);
    checkOutput("t4_level",     32'(level), 32'd1);
    waitNeg(1);
    checkOutput("t4_strobe",    32'(sram_we_n), 32'd0);
    checkOutput("t4_addr",      32'(sram_addr), 32'h00E01);
    waitNeg(8);
    checkOutput("t4_level_end", 32'(level), 32'd1);
    checkOutput("t4_strobes",   32'(st_addr.size()), 32'd1);
    checkOutput("t4_idle_oe",   32'(sram_dq_oe), 32'd0);

    // Reset mid-strobe: bus released and FIFO flushed on the next edge.
    step();
    wr_window = 1'b1;
    step();
    step();
    rst = 1'b1;
    wr_window = 1'b0;
    waitNeg(1);
    checkOutput("t5_in_strobe", 32'(sram_we_n), 32'd0);
    step();
    rst = 1'b0;
    waitNeg(1);
    checkOutput("t5_we_n",  32'(sram_we_n), 32'd1);
    checkOutput("t5_oe",    32'(sram_dq_oe), 32'd0);
    checkOutput("t5_level", 32'(level), 32'd0);
    checkOutput("t5_ovf",   32'(overflow), 32'd0);

    // Back-to-back pushes into an empty queue with the window open.
    step();
    wr_window = 1'b1;
    clearLog();
    applyStimulus(1'b1, 9'd20, 9'd30, 15'h1234);
    applyStimulus(1'b1, 9'd21, 9'd31, 15'h2345);
    applyStimulus(1'b1, 9'd22, 9'd32, 15'h3456);
    cmd_if.in_valid = 1'b0;
    waitNeg(16);
    checkOutput("t6_strobes", 32'(st_addr.size()), 32'd3);
    if (st_addr.size() == 3) begin
      checkOutput("t6_addr0", 32'(st_addr[0]), 32'h0281E);
      checkOutput("t6_data1", 32'(st_data[1]), 32'h2345);
    end

    step();
    wr_window = 1'b0;
    waitNeg(2);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
